rename_stage: RTL and testbench

- Parametrised, group-atomic register-rename stage between decode and dispatch.
- Holds a speculative RAT (SRAT) and a retirement RAT (RRAT). Allocates destination pregs from the free list.
- Resolves intra-group RAW/WAW dependencies and returns the previous mapping (old_prd) so the ROB can free it at commit.
- Output is registered behind a valid/ready handshake; a flush restores the SRAT from the RRAT.

---
 rtl/rename_stage_pkg.sv | 11 +
 rtl/rename_stage_if.sv | 45 ++++
 rtl/rename_bypass.sv | 32 +++
 rtl/rename_stage.sv | 216 +++++++++++++++++++++
 tb/tb_rename_stage.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_stage_pkg.sv
// Shared rename-stage constants and architectural/physical register index types.
// Pure declarations; no logic.
package rename_stage_pkg;
    localparam int FRONTEND_WIDTH      = 2;
    localparam int ARCH_REGS           = 32;
    localparam int PHYS_REGS           = 64;
    localparam int PHYS_REGS_ADDR_SIZE = $clog2(PHYS_REGS);

    typedef logic [4:0]                     areg_t;
    typedef logic [PHYS_REGS_ADDR_SIZE-1:0] preg_t;
endpackage

// File: rtl/rename_stage_if.sv
// Decode-side and dispatch-side group channels of the rename stage.
// The stage uses the slave view; the decode/dispatch environment uses the master view.
interface rename_stage_if
    import rename_stage_pkg::*;
#(
    parameter int WIDTH  = FRONTEND_WIDTH,
    parameter int PREG_W = PHYS_REGS_ADDR_SIZE
);
    logic                         dec_valid_i;
    logic                         dec_ready_o;
    logic [WIDTH-1:0]             dec_slot_v_i;
    logic [WIDTH-1:0]             dec_rd_v_i;
    logic [WIDTH-1:0]             dec_rs1_v_i;
    logic [WIDTH-1:0]             dec_rs2_v_i;
    areg_t [WIDTH-1:0]            dec_rd_i;
    areg_t [WIDTH-1:0]            dec_rs1_i;
    areg_t [WIDTH-1:0]            dec_rs2_i;

    logic                         disp_valid_o;
    logic                         disp_ready_i;
    logic [WIDTH-1:0]             disp_slot_v_o;
    logic [WIDTH-1:0]             disp_rd_v_o;
    logic [WIDTH-1:0][PREG_W-1:0] disp_prd_o;
    logic [WIDTH-1:0][PREG_W-1:0] disp_prs1_o;
    logic [WIDTH-1:0][PREG_W-1:0] disp_prs2_o;
    logic [WIDTH-1:0][PREG_W-1:0] disp_old_prd_o;

    modport slave (
        input  dec_valid_i, dec_slot_v_i, dec_rd_v_i, dec_rs1_v_i, dec_rs2_v_i,
        input  dec_rd_i, dec_rs1_i, dec_rs2_i,
        output dec_ready_o,
        output disp_valid_o, disp_slot_v_o, disp_rd_v_o,
        output disp_prd_o, disp_prs1_o, disp_prs2_o, disp_old_prd_o,
        input  disp_ready_i
    );

    modport master (
        output dec_valid_i, dec_slot_v_i, dec_rd_v_i, dec_rs1_v_i, dec_rs2_v_i,
        output dec_rd_i, dec_rs1_i, dec_rs2_i,
        input  dec_ready_o,
        input  disp_valid_o, disp_slot_v_o, disp_rd_v_o,
        input  disp_prd_o, disp_prs1_o, disp_prs2_o, disp_old_prd_o,
        output disp_ready_i
    );
endinterface

// File: rtl/rename_bypass.sv
// Intra-group priority match: each query takes the preg of the youngest older allocating slot
// writing the same arch reg, else its SRAT value; purely combinational, no backpressure.
module rename_bypass
    import rename_stage_pkg::*;
#(
    parameter int WIDTH  = FRONTEND_WIDTH,
    parameter int PREG_W = PHYS_REGS_ADDR_SIZE
) (
    input  logic [WIDTH-1:0]             alloc_i,
    input  areg_t [WIDTH-1:0]            rd_i,
    input  logic [WIDTH-1:0][PREG_W-1:0] prd_i,
    input  logic [WIDTH-1:0]             q_v_i,
    input  areg_t [WIDTH-1:0]            q_arch_i,
    input  logic [WIDTH-1:0][PREG_W-1:0] q_srat_i,
    output logic [WIDTH-1:0][PREG_W-1:0] q_preg_o
);
    always_comb begin
        q_preg_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            q_preg_o[i] = q_srat_i[i];
            // Ascending scan so the youngest older writer overrides earlier ones.
            for (int j = 0; j < i; j++) begin
                if (alloc_i[j] && (rd_i[j] == q_arch_i[i])) begin
                    q_preg_o[i] = prd_i[j];
                end
            end
            if (!q_v_i[i] || (q_arch_i[i] == '0)) begin
                q_preg_o[i] = '0;
            end
        end
    end
endmodule

// File: rtl/rename_stage.sv
// Group-atomic register rename (SRAT/RRAT, free-list alloc, flush restore); optional RENAME_PERF_CNT_EN stall counters.
// Latency 1 cycle; decode stalls on full output register, short free list, or flush.
module rename_stage #(
    parameter int  WIDTH     = rename_stage_pkg::FRONTEND_WIDTH,
    parameter int  ARCH_REGS = rename_stage_pkg::ARCH_REGS,
    parameter int  PHYS_REGS = rename_stage_pkg::PHYS_REGS,
    localparam int PREG_W    = $clog2(PHYS_REGS),
    localparam int AW        = $clog2(WIDTH + 1)
) (
    input  logic                                clk,
    input  logic                                resetn,
    rename_stage_if.slave                       dif,
    input  logic [AW-1:0]                       fl_avail_i,
    input  logic [WIDTH-1:0][PREG_W-1:0]        fl_preg_i,
    output logic [AW-1:0]                       fl_pop_o,
    input  logic [WIDTH-1:0]                    commit_v_i,
    input  rename_stage_pkg::areg_t [WIDTH-1:0] commit_rd_i,
    input  logic [WIDTH-1:0][PREG_W-1:0]        commit_prd_i,
    input  logic                                flush_i
`ifdef RENAME_PERF_CNT_EN
    ,
    output logic [31:0]                         perf_stall_fl_o,
    output logic [31:0]                         perf_stall_disp_o
`endif
);
    import rename_stage_pkg::*;

    logic [WIDTH-1:0]             alloc;
    logic [AW-1:0]                need;
    logic [WIDTH-1:0][AW-1:0]     fl_idx;
    logic [WIDTH-1:0][PREG_W-1:0] new_prd;
    logic [WIDTH-1:0][PREG_W-1:0] srat_rs1, srat_rs2, srat_rd;
    logic [WIDTH-1:0][PREG_W-1:0] prs1, prs2, old_prd;
    logic                         dec_ready, fire;

    logic [PREG_W-1:0] srat_q [ARCH_REGS];
    logic [PREG_W-1:0] srat_d [ARCH_REGS];
    logic [PREG_W-1:0] rrat_q [ARCH_REGS];
    logic [PREG_W-1:0] rrat_d [ARCH_REGS];

    logic                         disp_vld_q, disp_vld_d;
    logic [WIDTH-1:0]             disp_slot_v_q, disp_rd_v_q;
    logic [WIDTH-1:0][PREG_W-1:0] disp_prd_q, disp_prs1_q, disp_prs2_q, disp_old_q;

    // Slot i takes the free-list entry indexed by the number of older allocating slots.
    always_comb begin
        alloc   = '0;
        need    = '0;
        fl_idx  = '0;
        new_prd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            alloc[i]  = dif.dec_slot_v_i[i] && dif.dec_rd_v_i[i] && (dif.dec_rd_i[i] != '0);
            fl_idx[i] = need;
            if (alloc[i]) begin
                need = need + AW'(1);
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (alloc[i] && (fl_idx[i] == AW'(k))) begin
                    new_prd[i] = fl_preg_i[k];
                end
            end
        end
    end

    always_comb begin
        srat_rs1 = '0;
        srat_rs2 = '0;
        srat_rd  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            srat_rs1[i] = srat_q[dif.dec_rs1_i[i]];
            srat_rs2[i] = srat_q[dif.dec_rs2_i[i]];
            srat_rd[i]  = srat_q[dif.dec_rd_i[i]];
        end
    end

    // resetn gates acceptance so a group presented during reset is dropped without popping.
    assign dec_ready       = resetn && !flush_i && (!disp_vld_q || dif.disp_ready_i)
                             && (fl_avail_i >= need);
    assign fire            = dif.dec_valid_i && dec_ready;
    assign dif.dec_ready_o = dec_ready;
    assign fl_pop_o        = fire ? need : '0;

    rename_bypass #(.WIDTH(WIDTH), .PREG_W(PREG_W)) u_byp_rs1 (
        .alloc_i  (alloc),
        .rd_i     (dif.dec_rd_i),
        .prd_i    (new_prd),
        .q_v_i    (dif.dec_rs1_v_i),
        .q_arch_i (dif.dec_rs1_i),
        .q_srat_i (srat_rs1),
        .q_preg_o (prs1)
    );

    rename_bypass #(.WIDTH(WIDTH), .PREG_W(PREG_W)) u_byp_rs2 (
        .alloc_i  (alloc),
        .rd_i     (dif.dec_rd_i),
        .prd_i    (new_prd),
        .q_v_i    (dif.dec_rs2_v_i),
        .q_arch_i (dif.dec_rs2_i),
        .q_srat_i (srat_rs2),
        .q_preg_o (prs2)
    );

    rename_bypass #(.WIDTH(WIDTH), .PREG_W(PREG_W)) u_byp_old (
        .alloc_i  (alloc),
        .rd_i     (dif.dec_rd_i),
        .prd_i    (new_prd),
        .q_v_i    (alloc),
        .q_arch_i (dif.dec_rd_i),
        .q_srat_i (srat_rd),
        .q_preg_o (old_prd)
    );

    // Highest commit slot wins an RRAT write conflict.
    always_comb begin
        rrat_d = rrat_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (commit_v_i[i] && (commit_rd_i[i] != '0)) begin
                rrat_d[commit_rd_i[i]] = commit_prd_i[i];
            end
        end
    end

    // Flush restores from the post-commit RRAT so same-cycle retirements are not lost.
    always_comb begin
        srat_d = srat_q;
        if (flush_i) begin
            srat_d = rrat_d;
        end else if (fire) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (alloc[i]) begin
                    srat_d[dif.dec_rd_i[i]] = new_prd[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                srat_q[r] <= PREG_W'(r);
                rrat_q[r] <= PREG_W'(r);
            end
        end else begin
            srat_q <= srat_d;
            rrat_q <= rrat_d;
        end
    end

    always_comb begin
        disp_vld_d = disp_vld_q;
        if (flush_i) begin
            disp_vld_d = 1'b0;
        end else if (fire) begin
            disp_vld_d = 1'b1;
        end else if (dif.disp_ready_i) begin
            disp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            disp_vld_q    <= 1'b0;
            disp_slot_v_q <= '0;
            disp_rd_v_q   <= '0;
            disp_prd_q    <= '0;
            disp_prs1_q   <= '0;
            disp_prs2_q   <= '0;
            disp_old_q    <= '0;
        end else begin
            disp_vld_q <= disp_vld_d;
            if (fire) begin
                disp_slot_v_q <= dif.dec_slot_v_i;
                disp_rd_v_q   <= alloc;
                disp_prd_q    <= new_prd;
                disp_prs1_q   <= prs1;
                disp_prs2_q   <= prs2;
                disp_old_q    <= old_prd;
            end
        end
    end

    assign dif.disp_valid_o   = disp_vld_q;
    assign dif.disp_slot_v_o  = disp_slot_v_q;
    assign dif.disp_rd_v_o    = disp_rd_v_q;
    assign dif.disp_prd_o     = disp_prd_q;
    assign dif.disp_prs1_o    = disp_prs1_q;
    assign dif.disp_prs2_o    = disp_prs2_q;
    assign dif.disp_old_prd_o = disp_old_q;

`ifdef RENAME_PERF_CNT_EN
    logic [31:0] stall_fl_q, stall_disp_q;
    logic        stall_fl, stall_disp;

    assign stall_fl   = dif.dec_valid_i && (fl_avail_i < need);
    assign stall_disp = dif.dec_valid_i && disp_vld_q && !dif.disp_ready_i;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_fl_q   <= '0;
            stall_disp_q <= '0;
        end else begin
            if (stall_fl && (stall_fl_q != '1)) begin
                stall_fl_q <= stall_fl_q + 32'd1;
            end
            if (stall_disp && (stall_disp_q != '1)) begin
                stall_disp_q <= stall_disp_q + 32'd1;
            end
        end
    end

    assign perf_stall_fl_o   = stall_fl_q;
    assign perf_stall_disp_o = stall_disp_q;
`endif
endmodule

// File: tb/tb_rename_stage.sv
// Self-checking bench for rename_stage: directed table plus randomized traffic vs a sequential rename model.
module tb_rename_stage;
    localparam int W  = 2;
    localparam int PW = 6;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    rename_stage_if #(.WIDTH(W), .PREG_W(PW)) dif ();

    logic [AW-1:0]        fl_avail;
    logic [W-1:0][PW-1:0] fl_preg;
    logic [AW-1:0]        fl_pop;
    logic [W-1:0]         commit_v;
    logic [W-1:0][4:0]    commit_rd;
    logic [W-1:0][PW-1:0] commit_prd;
    logic                 flush;
`ifdef RENAME_PERF_CNT_EN
    logic [31:0]          perf_fl, perf_disp;
`endif

    rename_stage #(.WIDTH(W), .ARCH_REGS(32), .PHYS_REGS(64)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .dif          (dif),
        .fl_avail_i   (fl_avail),
        .fl_preg_i    (fl_preg),
        .fl_pop_o     (fl_pop),
        .commit_v_i   (commit_v),
        .commit_rd_i  (commit_rd),
        .commit_prd_i (commit_prd),
        .flush_i      (flush)
`ifdef RENAME_PERF_CNT_EN
        ,
        .perf_stall_fl_o   (perf_fl),
        .perf_stall_disp_o (perf_disp)
`endif
    );

    typedef struct {
        logic                 dec_valid;
        logic [W-1:0]         slot_v, rd_v, rs1_v, rs2_v;
        logic [W-1:0][4:0]    rd, rs1, rs2;
        logic [AW-1:0]        avail;
        logic [W-1:0][PW-1:0] fl;
        logic                 disp_ready, flush;
        logic [W-1:0]         commit_v;
        logic [W-1:0][4:0]    commit_rd;
        logic [W-1:0][PW-1:0] commit_prd;
    } stim_t;

    typedef struct {
        stim_t       s;
        bit          e_ready;
        int          e_pop;
        bit          e_vld;
        bit          chk_pay;
        logic [51:0] e_pay;
    } vec_t;

    int errors = 0;
    int checks = 0;

    stim_t st;
    int    m_srat[32], m_rrat[32];
    bit    m_vld;
    logic [W-1:0] m_slot_v, m_rdv;
    int    m_prd[W], m_prs1[W], m_prs2[W], m_old[W];
    int    m_need, m_pop, m_pfl, m_pdisp;
    bit    m_ready, m_fire;
    logic  a_ready;
    logic [AW-1:0] a_pop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [51:0] dut_pay();
        return {dif.disp_slot_v_o, dif.disp_rd_v_o, dif.disp_prd_o, dif.disp_prs1_o,
                dif.disp_prs2_o, dif.disp_old_prd_o};
    endfunction

    function automatic logic [51:0] model_pay();
        logic [W-1:0][PW-1:0] a, b, c, d;
        for (int i = 0; i < W; i++) begin
            a[i] = PW'(m_prd[i]);  b[i] = PW'(m_prs1[i]);
            c[i] = PW'(m_prs2[i]); d[i] = PW'(m_old[i]);
        end
        return {m_slot_v, m_rdv, a, b, c, d};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_srat[r] = r;
            m_rrat[r] = r;
        end
        m_vld = 0; m_slot_v = '0; m_rdv = '0;
        for (int i = 0; i < W; i++) begin
            m_prd[i] = 0; m_prs1[i] = 0; m_prs2[i] = 0; m_old[i] = 0;
        end
        m_pfl = 0; m_pdisp = 0;
    endtask

    // Rename the group one instruction at a time against a scratch map table.
    task automatic model_step();
        int tmp[32];
        int n;
        m_need = 0;
        for (int i = 0; i < W; i++)
            if (st.slot_v[i] && st.rd_v[i] && st.rd[i] != 0) m_need++;
        m_ready = !st.flush && (!m_vld || st.disp_ready) && (int'(st.avail) >= m_need);
        m_fire  = st.dec_valid && m_ready;
        m_pop   = m_fire ? m_need : 0;
        if (st.dec_valid && int'(st.avail) < m_need) m_pfl++;
        if (st.dec_valid && m_vld && !st.disp_ready) m_pdisp++;
        for (int i = 0; i < W; i++)
            if (st.commit_v[i] && st.commit_rd[i] != 0) m_rrat[st.commit_rd[i]] = int'(st.commit_prd[i]);
        if (st.flush) begin
            m_srat = m_rrat;
            m_vld  = 0;
        end else if (m_fire) begin
            tmp = m_srat;
            n   = 0;
            for (int i = 0; i < W; i++) begin
                m_prs1[i] = (st.rs1_v[i] && st.rs1[i] != 0) ? tmp[st.rs1[i]] : 0;
                m_prs2[i] = (st.rs2_v[i] && st.rs2[i] != 0) ? tmp[st.rs2[i]] : 0;
                if (st.slot_v[i] && st.rd_v[i] && st.rd[i] != 0) begin
                    m_old[i] = tmp[st.rd[i]];
                    m_prd[i] = int'(st.fl[n]);
                    tmp[st.rd[i]] = m_prd[i];
                    m_rdv[i] = 1'b1;
                    n++;
                end else begin
                    m_old[i] = 0;
                    m_prd[i] = 0;
                    m_rdv[i] = 1'b0;
                end
            end
            m_slot_v = st.slot_v;
            m_srat   = tmp;
            m_vld    = 1;
        end else if (st.disp_ready) begin
            m_vld = 0;
        end
    endtask

    task automatic drive();
        dif.dec_valid_i  = st.dec_valid;
        dif.dec_slot_v_i = st.slot_v;
        dif.dec_rd_v_i   = st.rd_v;
        dif.dec_rs1_v_i  = st.rs1_v;
        dif.dec_rs2_v_i  = st.rs2_v;
        dif.dec_rd_i     = st.rd;
        dif.dec_rs1_i    = st.rs1;
        dif.dec_rs2_i    = st.rs2;
        dif.disp_ready_i = st.disp_ready;
        fl_avail   = st.avail;
        fl_preg    = st.fl;
        flush      = st.flush;
        commit_v   = st.commit_v;
        commit_rd  = st.commit_rd;
        commit_prd = st.commit_prd;
    endtask

    // Drive at the falling edge, sample combinational outputs 1ns later and registered ones at the next falling edge.
    task automatic apply_cycle(input bit mchk);
        drive();
        #1;
        model_step();
        a_ready = dif.dec_ready_o;
        a_pop   = fl_pop;
        if (mchk) begin
            chk("rnd_dec_ready", 64'(a_ready), 64'(m_ready));
            chk("rnd_fl_pop", 64'(a_pop), 64'(m_pop));
        end
        @(posedge clk);
        @(negedge clk);
        if (mchk) begin
            chk("rnd_disp_valid", 64'(dif.disp_valid_o), 64'(m_vld));
            chk("rnd_payload", 64'(dut_pay()), 64'(model_pay()));
        end
    endtask

    function automatic stim_t g(bit dv, bit [1:0] sv, bit [1:0] rdv, bit [1:0] r1v,
                                int rd0, int rd1, int s0, int s1, int av, int f0, int f1,
                                bit dr, bit fl, bit [1:0] cv, int crd, int cprd);
        stim_t s;
        s = '{default: '0};
        s.dec_valid = dv; s.slot_v = sv; s.rd_v = rdv; s.rs1_v = r1v;
        s.rd[0] = 5'(rd0);  s.rd[1] = 5'(rd1);
        s.rs1[0] = 5'(s0);  s.rs1[1] = 5'(s1);
        s.avail = AW'(av);
        s.fl[0] = PW'(f0);  s.fl[1] = PW'(f1);
        s.disp_ready = dr;  s.flush = fl;
        s.commit_v = cv;    s.commit_rd[0] = 5'(crd); s.commit_prd[0] = PW'(cprd);
        return s;
    endfunction

    function automatic vec_t row(stim_t s, bit er, int ep, bit ev, bit cp, bit [1:0] sv, bit [1:0] rdv,
                                 int p0, int p1, int s0, int s1, int o0, int o1);
        vec_t v;
        v.s = s; v.e_ready = er; v.e_pop = ep; v.e_vld = ev; v.chk_pay = cp;
        v.e_pay = {sv, rdv, PW'(p1), PW'(p0), PW'(s1), PW'(s0), 12'd0, PW'(o1), PW'(o0)};
        return v;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s = '{default: '0};
        s.dec_valid = ($urandom_range(0, 9) < 8);
        s.slot_v = 2'($urandom); s.rd_v = 2'($urandom);
        s.rs1_v  = 2'($urandom); s.rs2_v = 2'($urandom);
        for (int i = 0; i < W; i++) begin
            s.rd[i]  = 5'($urandom_range(0, 7));
            s.rs1[i] = 5'($urandom_range(0, 7));
            s.rs2[i] = 5'($urandom_range(0, 7));
            s.fl[i]  = PW'($urandom_range(1, 63));
            s.commit_v[i]   = ($urandom_range(0, 9) < 3);
            s.commit_rd[i]  = 5'($urandom_range(0, 7));
            s.commit_prd[i] = PW'($urandom_range(0, 63));
        end
        s.avail      = AW'($urandom_range(0, 2));
        s.disp_ready = ($urandom_range(0, 3) != 0);
        s.flush      = ($urandom_range(0, 31) == 0);
        return s;
    endfunction

    initial begin
        vec_t tbl[$];

        tbl.push_back(row(g(1,2'b11,2'b11,2'b11, 5,6, 5,5, 2,40,41, 1,0,2'b00,0,0), 1,2,1,1, 2'b11,2'b11, 40,41, 5,40, 5,6));
        tbl.push_back(row(g(1,2'b11,2'b11,2'b00, 7,7, 0,0, 2,50,51, 1,0,2'b00,0,0), 1,2,1,1, 2'b11,2'b11, 50,51, 0,0, 7,50));
        tbl.push_back(row(g(1,2'b01,2'b00,2'b01, 0,0, 7,0, 0,0,0,   1,0,2'b00,0,0), 1,0,1,1, 2'b01,2'b00, 0,0, 51,0, 0,0));
        tbl.push_back(row(g(1,2'b11,2'b11,2'b00, 8,9, 0,0, 1,60,61, 1,0,2'b00,0,0), 0,0,0,0, 2'b00,2'b00, 0,0, 0,0, 0,0));
        tbl.push_back(row(g(1,2'b11,2'b11,2'b00, 8,9, 0,0, 2,60,61, 1,0,2'b00,0,0), 1,2,1,1, 2'b11,2'b11, 60,61, 0,0, 8,9));
        for (int k = 0; k < 3; k++)
            tbl.push_back(row(g(1,2'b01,2'b01,2'b00, 10,0, 0,0, 2,70,71, 0,0,2'b00,0,0), 0,0,1,1, 2'b11,2'b11, 60,61, 0,0, 8,9));
        tbl.push_back(row(g(1,2'b01,2'b01,2'b00, 10,0, 0,0, 2,70,71, 1,0,2'b00,0,0), 1,1,1,1, 2'b01,2'b01, 70,0, 0,0, 10,0));
        tbl.push_back(row(g(1,2'b01,2'b01,2'b00, 3,0, 0,0, 2,44,45, 1,0,2'b00,0,0), 1,1,1,1, 2'b01,2'b01, 44,0, 0,0, 3,0));
        tbl.push_back(row(g(0,2'b00,2'b00,2'b00, 0,0, 0,0, 2,0,0,   1,0,2'b01,3,44), 1,0,0,0, 2'b00,2'b00, 0,0, 0,0, 0,0));
        tbl.push_back(row(g(1,2'b01,2'b01,2'b00, 3,0, 0,0, 2,45,46, 1,0,2'b00,0,0), 1,1,1,1, 2'b01,2'b01, 45,0, 0,0, 44,0));
        tbl.push_back(row(g(1,2'b01,2'b01,2'b00, 3,0, 0,0, 2,47,48, 1,1,2'b00,0,0), 0,0,0,0, 2'b00,2'b00, 0,0, 0,0, 0,0));
        tbl.push_back(row(g(1,2'b01,2'b00,2'b01, 0,0, 3,0, 0,0,0,   1,0,2'b00,0,0), 1,0,1,1, 2'b01,2'b00, 0,0, 44,0, 0,0));
        tbl.push_back(row(g(1,2'b01,2'b01,2'b01, 0,0, 0,0, 0,0,0,   1,0,2'b00,0,0), 1,0,1,1, 2'b01,2'b00, 0,0, 0,0, 0,0));
        tbl.push_back(row(g(1,2'b01,2'b01,2'b00, 4,0, 0,0, 2,52,53, 1,0,2'b00,0,0), 1,1,1,1, 2'b01,2'b01, 52,0, 0,0, 4,0));
        tbl.push_back(row(g(1,2'b01,2'b01,2'b00, 4,0, 0,0, 2,54,55, 1,1,2'b01,4,52), 0,0,0,0, 2'b00,2'b00, 0,0, 0,0, 0,0));
        tbl.push_back(row(g(1,2'b01,2'b00,2'b01, 0,0, 4,0, 0,0,0,   1,0,2'b00,0,0), 1,0,1,1, 2'b01,2'b00, 0,0, 52,0, 0,0));
        tbl.push_back(row(g(1,2'b00,2'b00,2'b00, 0,0, 0,0, 0,0,0,   1,0,2'b00,0,0), 1,0,1,1, 2'b00,2'b00, 0,0, 0,0, 0,0));

        st = g(0,2'b00,2'b00,2'b00, 0,0, 0,0, 0,0,0, 1,0,2'b00,0,0);
        drive();
        model_reset();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("reset_disp_valid", 64'(dif.disp_valid_o), 64'd0);
        chk("reset_payload", 64'(dut_pay()), 64'd0);
        chk("reset_fl_pop", 64'(fl_pop), 64'd0);

        foreach (tbl[k]) begin
            st = tbl[k].s;
            apply_cycle(1'b0);
            chk($sformatf("tbl%0d_dec_ready", k), 64'(a_ready), 64'(tbl[k].e_ready));
            chk($sformatf("tbl%0d_fl_pop", k), 64'(a_pop), 64'(tbl[k].e_pop));
            chk($sformatf("tbl%0d_disp_valid", k), 64'(dif.disp_valid_o), 64'(tbl[k].e_vld));
            if (tbl[k].chk_pay)
                chk($sformatf("tbl%0d_payload", k), 64'(dut_pay()), 64'(tbl[k].e_pay));
        end
`ifdef RENAME_PERF_CNT_EN
        chk("tbl_perf_stall_fl", 64'(perf_fl), 64'(m_pfl));
        chk("tbl_perf_stall_disp", 64'(perf_disp), 64'(m_pdisp));
`endif

        for (int c = 0; c < 1500; c++) begin
            st = rnd_stim();
            apply_cycle(1'b1);
        end
`ifdef RENAME_PERF_CNT_EN
        chk("rnd_perf_stall_fl", 64'(perf_fl), 64'(m_pfl));
        chk("rnd_perf_stall_disp", 64'(perf_disp), 64'(m_pdisp));
`endif

        // Reset asserted while a renameable group is presented: nothing pops, output clears.
        st = g(1,2'b11,2'b11,2'b00, 1,2, 0,0, 2,30,31, 1,0,2'b00,0,0);
        drive();
        #1;
        resetn = 1'b0;
        #1;
        chk("midrst_dec_ready", 64'(dif.dec_ready_o), 64'd0);
        chk("midrst_fl_pop", 64'(fl_pop), 64'd0);
        chk("midrst_disp_valid", 64'(dif.disp_valid_o), 64'd0);
        chk("midrst_payload", 64'(dut_pay()), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        for (int c = 0; c < 200; c++) begin
            st = rnd_stim();
            apply_cycle(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
